// File: rtl/seg_capture.sv
// seg_capture: reader side of the multiplexed 7-segment display path.
// Samples an active-low segment bus plus active-low digit enables, waits for
// each digit's pattern to settle, decodes it back to a hex value and decimal
// point, and keeps one shadow register per digit.
// Optional macro SEG_CAPTURE_SYNC_EN adds a two-flop synchronizer ahead of the
// input register for buses arriving from a pin or another clock domain.
module seg_capture #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic                    upd_valid,
    output logic [2:0]              upd_idx,
    output logic [3:0]              upd_value,
    output logic                    err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_capture;

    logic [7:0]              w_seg_src;
    logic [NUM_DIGITS-1:0]   w_an_src;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_prev_seg;
    logic [NUM_DIGITS-1:0]   r_prev_an;
    logic [2:0]              r_prev_idx;

    logic [3:0]              w_zeros;
    logic [2:0]              w_idx;
    logic                    w_sel_valid;
    logic                    w_changed;
    logic [4:0]              w_dec;
    logic                    w_blank_pat;
    logic [3:0]              w_cnt_last;

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic                    r_upd_valid;
    logic [2:0]              r_upd_idx;
    logic [3:0]              r_upd_value;
    logic                    r_err;

`ifdef SEG_CAPTURE_SYNC_EN
    logic [7:0]              r_seg_s1;
    logic [7:0]              r_seg_s2;
    logic [NUM_DIGITS-1:0]   r_an_s1;
    logic [NUM_DIGITS-1:0]   r_an_s2;

    // Two-flop synchronizer; idles at all-ones (everything off / deselected).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_an_s1  <= '1;
            r_an_s2  <= '1;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
        end
    end

    assign w_seg_src = r_seg_s2;
    assign w_an_src  = r_an_s2;
`else
    assign w_seg_src = seg_in;
    assign w_an_src  = an_in;
`endif

    // Decode the seven segment bits (a..g, active-low) to a hex digit; bit 4 = hit.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'b0000001: f_decode = {1'b1, 4'h0};
            7'b1001111: f_decode = {1'b1, 4'h1};
            7'b0010010: f_decode = {1'b1, 4'h2};
            7'b0000110: f_decode = {1'b1, 4'h3};
            7'b1001100: f_decode = {1'b1, 4'h4};
            7'b0100100: f_decode = {1'b1, 4'h5};
            7'b0100000: f_decode = {1'b1, 4'h6};
            7'b0001111: f_decode = {1'b1, 4'h7};
            7'b0000000: f_decode = {1'b1, 4'h8};
            7'b0000100: f_decode = {1'b1, 4'h9};
            7'b0001000: f_decode = {1'b1, 4'hA};
            7'b1100000: f_decode = {1'b1, 4'hB};
            7'b0110001: f_decode = {1'b1, 4'hC};
            7'b1000010: f_decode = {1'b1, 4'hD};
            7'b0110000: f_decode = {1'b1, 4'hE};
            7'b0111000: f_decode = {1'b1, 4'hF};
            default:    f_decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Input register plus one-cycle history used for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '1;
            r_an       <= '1;
            r_prev_seg <= '1;
            r_prev_an  <= '1;
            r_prev_idx <= '0;
        end else begin
            r_seg      <= w_seg_src;
            r_an       <= w_an_src;
            r_prev_seg <= r_seg;
            r_prev_an  <= r_an;
            r_prev_idx <= w_idx;
        end
    end

    // Select is valid when exactly one enable is low; its position is the digit index.
    always_comb begin
        w_zeros = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = 3'(i);
            end
        end
        w_sel_valid = (w_zeros == 4'd1);
    end

    assign w_changed   = (r_seg != r_prev_seg) || (r_an != r_prev_an);
    assign w_cnt_last  = 4'(STABLE_CYCLES - 1);
    assign w_dec       = f_decode(r_prev_seg[7:1]);
    assign w_blank_pat = (r_prev_seg[7:1] == 7'h7F);

    // State and settle-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: count identical samples, capture once per settled pattern.
    // The capture branch is tested before change/invalid so that a change on the
    // capture cycle still captures the previous (settled) sample held in r_prev_*.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_sel_valid) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == w_cnt_last) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = '0;
                    if (!w_sel_valid) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_changed) begin
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end else if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_changed) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                w_cnt_nxt = '0;
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_changed) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture: update the addressed shadow register and raise one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value     <= '0;
            r_blank     <= '1;
            r_dp        <= '0;
            r_upd_valid <= 1'b0;
            r_upd_idx   <= '0;
            r_upd_value <= '0;
            r_err       <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;
            r_err       <= 1'b0;
            if (w_capture) begin
                if (w_dec[4] || w_blank_pat) begin
                    r_upd_valid <= 1'b1;
                    r_upd_idx   <= r_prev_idx;
                    r_upd_value <= w_dec[4] ? w_dec[3:0] : 4'h0;
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (3'(i) == r_prev_idx) begin
                            r_dp[i]    <= ~r_prev_seg[0];
                            r_blank[i] <= w_blank_pat;
                            if (w_dec[4]) begin
                                r_value[4*i +: 4] <= w_dec[3:0];
                            end
                        end
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign value_o   = r_value;
    assign blank_o   = r_blank;
    assign dp_o      = r_dp;
    assign upd_valid = r_upd_valid;
    assign upd_idx   = r_upd_idx;
    assign upd_value = r_upd_value;
    assign err       = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: directed steps plus a randomized phase, checked
// against a run-length reference model of the input history.
module tb_seg_capture;

    localparam int unsigned ND = 8;
    localparam int unsigned S  = 4;
`ifdef SEG_CAPTURE_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    seg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] value_o;
    logic [ND-1:0] blank_o;
    logic [ND-1:0] dp_o;
    logic          upd_valid;
    logic [2:0]    upd_idx;
    logic [3:0]    upd_value;
    logic          err;

    int n_vec = 0;
    int n_err = 0;
    int n_pulses = 0;

    logic [7:0]  tbl [16];
    logic [15:0] hist [$];
    logic [3:0]  m_val [ND];
    logic [7:0]  m_blank;
    logic [7:0]  m_dp;

    seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .value_o   (value_o),
        .blank_o   (blank_o),
        .dp_o      (dp_o),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_value (upd_value),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sel_idx(input logic [7:0] an);
        int idx;
        idx = -1;
        if ($countones(~an) == 1) begin
            for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'hFFFF);
        for (int i = 0; i < int'(ND); i++) m_val[i] = 4'h0;
        m_blank = '1;
        m_dp    = '0;
    endtask

    // Caller is at posedge+1; drive, take one edge, then compare.
    task automatic step(input logic [7:0] s, input logic [7:0] a);
        int t, k, idx, code;
        bit run, exp_v, exp_e;
        logic [15:0] p;
        logic [3:0]  exp_uv;
        logic [31:0] pv;
        seg_in = s;
        an_in  = a;
        @(posedge clk);
        #1;
        hist.push_back({s, a});
        t = hist.size() - 2;
        k = t - int'(S) - 1 - EXTRA;
        exp_v = 0; exp_e = 0; exp_uv = 0; idx = 0;
        // A capture happens S+1 edges after the start of a run of S identical,
        // validly selected samples (start = differs from the sample before).
        if (k >= 0 && hist[k] != hist[k+1] && sel_idx(hist[k+1][7:0]) >= 0) begin
            run = 1;
            for (int j = 1; j < int'(S); j++) if (hist[k+1+j] != hist[k+1]) run = 0;
            if (run) begin
                p = hist[k+1];
                idx = sel_idx(p[7:0]);
                code = -1;
                for (int v = 0; v < 16; v++) if (tbl[v][7:1] == p[15:9]) code = v;
                if (code >= 0) begin
                    m_val[idx] = 4'(code);
                    m_blank[idx] = 1'b0;
                    m_dp[idx] = ~p[8];
                    exp_v = 1; exp_uv = 4'(code);
                end else if (p[15:9] == 7'h7F) begin
                    m_blank[idx] = 1'b1;
                    m_dp[idx] = ~p[8];
                    exp_v = 1; exp_uv = 4'h0;
                end else begin
                    exp_e = 1;
                end
            end
        end
        if (upd_valid === 1'b1) n_pulses++;
        chk("upd_valid", 32'(upd_valid), 32'(exp_v));
        chk("err", 32'(err), 32'(exp_e));
        if (exp_v) begin
            chk("upd_idx", 32'(upd_idx), 32'(idx));
            chk("upd_value", 32'(upd_value), 32'(exp_uv));
        end
        pv = '0;
        for (int i = 0; i < int'(ND); i++) pv[4*i +: 4] = m_val[i];
        chk("value_o", value_o, pv);
        chk("blank_o", 32'(blank_o), 32'(m_blank));
        chk("dp_o", 32'(dp_o), 32'(m_dp));
    endtask

    task automatic hold(input logic [7:0] s, input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) step(s, a);
    endtask

    task automatic chk_reset_vals();
        chk("rst_value", value_o, 32'h0);
        chk("rst_blank", 32'(blank_o), 32'hFF);
        chk("rst_dp", 32'(dp_o), 32'h0);
        chk("rst_upd_valid", 32'(upd_valid), 32'h0);
        chk("rst_upd_idx", 32'(upd_idx), 32'h0);
        chk("rst_upd_value", 32'(upd_value), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
    endtask

    initial begin
        int pulses0, r, len;
        logic [7:0] s, a;
        tbl = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
                8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001};
        rst_n  = 1'b0;
        seg_in = '1;
        an_in  = '1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        model_reset();

        // Reset asserted in the middle of a settle window.
        hold(8'b00001101, 8'b11111011, 3);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        seg_in = '1;
        an_in  = '1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        hold(8'hFF, 8'hFF, S + 2 + EXTRA);

        // Basic capture: digit 2 shows "3".
        hold(8'b00001101, 8'b11111011, 10);
        chk("basic_value", 32'(value_o[11:8]), 32'h3);
        chk("basic_blank", 32'(blank_o[2]), 32'h0);

        // Glitching pattern on digit 0, then "1." held.
        for (int i = 0; i < 10; i++)
            hold((i % 2 == 0) ? 8'b00000011 : 8'b10011111, 8'b11111110, 2);
        hold(8'b10011110, 8'b11111110, 10);
        chk("glitch_dp", 32'(dp_o[0]), 32'h1);
        chk("glitch_value", 32'(value_o[3:0]), 32'h1);

        // Scan all digits with digit i showing i.
        for (int d = 0; d < 8; d++) begin
            a = ~(8'd1 << d);
            hold(tbl[d], a, 10);
        end
        chk("scan_value", value_o, 32'h76543210);

        // Undecodable pattern on digit 5, then blank.
        hold(8'b10101010, 8'b11011111, 10);
        chk("err_value_kept", 32'(value_o[23:20]), 32'h5);
        hold(8'b11111111, 8'b11011111, 10);
        chk("blank_set", 32'(blank_o[5]), 32'h1);

        // Same pattern re-driven on the same digit after leaving it.
        pulses0 = n_pulses;
        hold(tbl[9], 8'b11111101, 7);
        hold(8'hFF, 8'hFF, 3);
        hold(tbl[9], 8'b11111101, 7);
        chk("redrive_pulses", 32'(n_pulses - pulses0), 32'd2);

        // Invalid selects.
        pulses0 = n_pulses;
        hold(tbl[4], 8'b11110011, 10);
        hold(tbl[4], 8'hFF, 10);
        chk("invalid_pulses", 32'(n_pulses - pulses0), 32'd0);

        // Randomized mix of patterns, selects and hold lengths.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) a = ~(8'd1 << r);
            else if (r == 8) a = 8'($urandom);
            else a = 8'hFF;
            r = $urandom_range(0, 5);
            if (r < 4) begin
                s = tbl[$urandom_range(0, 15)];
                s[0] = 1'($urandom_range(0, 1));
            end else if (r == 4) s = {7'h7F, 1'($urandom_range(0, 1))};
            else s = 8'($urandom);
            len = $urandom_range(1, 8);
            hold(s, a, len);
        end
        hold(8'hFF, 8'hFF, S + 3 + EXTRA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
